// File: rtl/nes_poll_sequencer.sv
// NES gamepad poller: derives a protocol tick from inClock, runs the latch/pulse
// handshake once per poll period and publishes the 8 buttons with a valid strobe.
module nes_poll_sequencer #(
  parameter int BASE_SPEED = 200000000,
  parameter int TICK_HZ    = 166667,
  parameter int POLL_TICKS = 2778
) (
  input  logic       inClock,
  input  logic       reset,
  input  logic       enable,
  input  logic       nesData,
  output logic       nesLatch,
  output logic       nesPulse,
  output logic [7:0] buttons,
  output logic       buttonsValid,
  output logic       busy
);

  localparam int TICK_DIV = BASE_SPEED / TICK_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int POLL_W   = $clog2(POLL_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t            state, next_state;
  logic [TICK_W-1:0] tick_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [1:0]        sync_q;
  logic              phase;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tick, poll_due, sync_data;
  logic              latch_next, pulse_next;

  assign tick      = (tick_cnt == TICK_LAST);
  assign poll_due  = tick && (poll_cnt == POLL_LAST);
  assign sync_data = sync_q[1];

  // Tick and poll counters free-run in every state so the poll period never drifts.
  always_ff @(posedge inClock) begin
    if (reset) begin
      tick_cnt <= '0;
      poll_cnt <= '0;
      sync_q   <= 2'b11;
    end else begin
      sync_q   <= {sync_q[0], nesData};
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick)
        poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge inClock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (poll_due && enable) next_state = LATCH;
      LATCH: if (tick && phase) next_state = LOW;
      LOW:   if (tick) next_state = HIGH;
      HIGH:  if (tick) next_state = (bit_idx == 3'd7) ? DONE : LOW;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pin levels are decoded from the upcoming state and registered, so they
  // change exactly on the tick edge without decode glitches.
  always_comb begin
    latch_next = (next_state == LATCH);
    pulse_next = (next_state == HIGH);
    busy       = (state != IDLE);
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      nesLatch     <= 1'b0;
      nesPulse     <= 1'b0;
      phase        <= 1'b0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      buttons      <= 8'h00;
      buttonsValid <= 1'b0;
    end else begin
      nesLatch     <= latch_next;
      nesPulse     <= pulse_next;
      buttonsValid <= (state == DONE);
      case (state)
        IDLE:  phase <= 1'b0;
        LATCH: if (tick) begin
                 phase   <= 1'b1;
                 bit_idx <= 3'd0;
               end
        LOW:   if (tick) shift[3'd7 - bit_idx] <= ~sync_data;
        HIGH:  if (tick && bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
        DONE:  buttons <= shift;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Scoreboard bench for nes_poll_sequencer with a behavioural NES controller model.
module tb_nes_poll_sequencer;

  logic       inClock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       nesData;
  logic       nesLatch, nesPulse, buttonsValid, busy;
  logic [7:0] buttons;

  always #5 inClock = ~inClock;

  nes_poll_sequencer #(.BASE_SPEED(100), .TICK_HZ(10), .POLL_TICKS(25)) dut (
    .inClock(inClock), .reset(reset), .enable(enable), .nesData(nesData),
    .nesLatch(nesLatch), .nesPulse(nesPulse), .buttons(buttons),
    .buttonsValid(buttonsValid), .busy(busy)
  );

  // Controller model: latch loads pressed buttons, each pulse rise shifts the next one out (active-low).
  logic [7:0] pressed = 8'h00;
  logic [7:0] ctrl_sr = 8'h00;
  logic       ctrl_pulse_d = 1'b0;
  int         data_mode = 0;

  always @(posedge inClock) begin
    if (nesLatch) ctrl_sr <= pressed;
    else if (nesPulse && !ctrl_pulse_d) ctrl_sr <= {ctrl_sr[6:0], 1'b0};
    ctrl_pulse_d <= nesPulse;
  end

  assign nesData = (data_mode == 1) ? 1'b1 : (data_mode == 2) ? 1'b0 : ~ctrl_sr[7];

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  int cycle = 0;
  always @(posedge inClock) cycle++;

  // Scoreboard monitor: every strobe consumes one expectation.
  logic [7:0] exp_q[$];
  logic [7:0] exp_val;
  int         strobe_count = 0;
  int         last_strobe_cycle = 0;

  always @(negedge inClock) begin
    if (buttonsValid) begin
      checkOutput("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_val = exp_q.pop_front();
        checkOutput("buttons", buttons, exp_val);
      end
      last_strobe_cycle = cycle;
      strobe_count++;
    end
  end

  // Pin timing monitor: latch width, pulse widths and gaps, pulses per frame, idle gap.
  int   latch_run = 0, pulse_high = 0, pulse_low = 0, pulse_idx = 0, busy_low = 0;
  logic prev_pulse = 1'b0, prev_busy = 1'b0;

  always @(negedge inClock) begin
    if (reset) begin
      latch_run = 0; pulse_high = 0; pulse_low = 0; pulse_idx = 0;
      prev_pulse = 1'b0; prev_busy = 1'b0; busy_low = 0;
    end else begin
      if (nesLatch) begin
        latch_run++;
        pulse_idx = 0;
      end else if (latch_run != 0) begin
        checkOutput("latch_width", latch_run, 20);
        latch_run = 0;
      end
      if (nesPulse) begin
        if (!prev_pulse && pulse_idx > 0) checkOutput("pulse_low_gap", pulse_low, 10);
        if (!prev_pulse) pulse_idx++;
        pulse_high++;
      end else if (prev_pulse) begin
        checkOutput("pulse_high_width", pulse_high, 10);
        pulse_high = 0;
        pulse_low  = 1;
      end else begin
        pulse_low++;
      end
      if (buttonsValid) checkOutput("pulses_per_frame", pulse_idx, 8);
      if (busy && !prev_busy) checkOutput("idle_gap_ge_60", busy_low >= 60, 1);
      if (busy) busy_low = 0;
      else      busy_low++;
      prev_pulse = nesPulse;
      prev_busy  = busy;
    end
  end

  task automatic applyStimulus(input int mode, input logic [7:0] keys, input logic [7:0] expected);
    data_mode = mode;
    pressed   = keys;
    exp_q.push_back(expected);
  endtask

  task automatic waitStrobe(input int limit);
    int start;
    int n;
    start = strobe_count;
    n = 0;
    while (strobe_count == start && n < limit) begin
      @(negedge inClock);
      n++;
    end
    if (strobe_count == start) checkOutput("strobe_timeout", 0, 1);
  endtask

  task automatic waitLatch(input int limit);
    int n;
    n = 0;
    while (!nesLatch && n < limit) begin
      @(negedge inClock);
      n++;
    end
    if (!nesLatch) checkOutput("latch_timeout", 0, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_latch", nesLatch, 0);
    checkOutput("rst_pulse", nesPulse, 0);
    checkOutput("rst_buttons", buttons, 8'h00);
    checkOutput("rst_valid", buttonsValid, 0);
    checkOutput("rst_busy", busy, 0);
  endtask

  logic [1:0] vec_mode [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [7:0] vec_keys [5] = '{8'b1001_0010, 8'b0100_0101, 8'h00, 8'h00, 8'b1000_0001};
  logic [7:0] vec_exp  [5] = '{8'h92, 8'h45, 8'h00, 8'hFF, 8'h81};

  initial begin
    int prev_strobe;
    int latch_rises;
    logic prev_latch;

    repeat (3) @(negedge inClock);
    checkResetState();
    reset  = 1'b0;
    enable = 1'b1;

    // Directed frames back to back; consecutive strobes must be one poll period apart.
    prev_strobe = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(int'(vec_mode[i]), vec_keys[i], vec_exp[i]);
      waitStrobe(600);
      if (i > 0) checkOutput("poll_period", last_strobe_cycle - prev_strobe, 250);
      prev_strobe = last_strobe_cycle;
    end

    // Enable drops during bit 3: frame completes, then no latches for three periods.
    applyStimulus(0, 8'h69, 8'h69);
    waitLatch(300);
    repeat (85) @(negedge inClock);
    enable = 1'b0;
    waitStrobe(300);
    latch_rises = 0;
    prev_latch  = nesLatch;
    repeat (750) begin
      @(negedge inClock);
      if (nesLatch && !prev_latch) latch_rises++;
      prev_latch = nesLatch;
    end
    checkOutput("no_latch_while_disabled", latch_rises, 0);
    checkOutput("buttons_held", buttons, 8'h69);
    applyStimulus(0, 8'h3C, 8'h3C);
    enable = 1'b1;
    waitStrobe(500);

    // Reset during HIGH of bit 5 aborts the frame without a strobe.
    data_mode = 0;
    pressed   = 8'hF0;
    waitLatch(300);
    repeat (133) @(negedge inClock);
    reset = 1'b1;
    @(negedge inClock);
    checkResetState();
    @(negedge inClock);
    reset = 1'b0;
    applyStimulus(0, 8'hF0, 8'hF0);
    waitStrobe(600);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
